// File: rtl/dff_en_pipe_pkg.sv
// Shared defaults and sizing helpers for the dff_en_pipe elastic register pipeline.
package dff_en_pipe_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 4;

  // Occupancy must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_en_stage.sv
// One elastic pipeline stage: enable-gated data register plus its valid flop,
// with synchronous active-low reset and synchronous clear.
module dff_en_stage
  import dff_en_pipe_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic             i_src_valid,
  input  logic [WIDTH-1:0] i_src_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // its predecessor's pre-edge value and words shift exactly one stage per edge.
  always_ff @(posedge clk) begin
    if (!rst || i_clear) begin
      r_valid <= 1'b0;
      r_data  <= RESET_VAL;
    end else if (i_load) begin
      r_valid <= i_src_valid;
      // Data only moves when a real word arrives, so idle stages do not toggle.
      if (i_src_valid) r_data <= i_src_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/dff_en_pipe.sv
// Elastic register pipeline: DEPTH enabled stages with valid/ready on both ends,
// bubble collapse, synchronous flush and a registered occupancy count.
module dff_en_pipe
  import dff_en_pipe_pkg::*;
#(
  parameter  int               WIDTH     = DEF_WIDTH,
  parameter  int               DEPTH     = DEF_DEPTH,
  parameter  logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int               CNT_W     = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occupancy
);

  logic [DEPTH:0]   w_rdy;
  logic [DEPTH-1:0] w_v;
  logic [WIDTH-1:0] w_data [DEPTH];
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [CNT_W-1:0] r_occ;

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_rdy        = '0;
    w_rdy[DEPTH] = out_ready;
    // An empty stage is always ready, which lets bubbles collapse under a stall.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_rdy[i] = ~w_v[i] | w_rdy[i+1];
    end
  end

  assign in_ready   = w_rdy[0] & ~flush & rst;
  assign w_in_xfer  = in_valid & in_ready;
  assign out_valid  = w_v[DEPTH-1];
  assign out_data   = w_data[DEPTH-1];
  assign w_out_xfer = out_valid & out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             w_src_valid;
    logic [WIDTH-1:0] w_src_data;

    if (i == 0) begin : g_head
      assign w_src_valid = w_in_xfer;
      assign w_src_data  = in_data;
    end else begin : g_body
      assign w_src_valid = w_v[i-1];
      assign w_src_data  = w_data[i-1];
    end

    dff_en_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk         (clk),
      .rst         (rst),
      .i_clear     (flush),
      .i_load      (w_rdy[i]),
      .i_src_valid (w_src_valid),
      .i_src_data  (w_src_data),
      .o_valid     (w_v[i]),
      .o_data      (w_data[i])
    );
  end

  // A word leaving during a flush edge still counts as delivered; the clear wins.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      r_occ <= '0;
    end else begin
      r_occ <= r_occ + CNT_W'(w_in_xfer) - CNT_W'(w_out_xfer);
    end
  end

  assign occupancy = r_occ;

endmodule

// File: tb/tb_dff_en_pipe.sv
// Directed and randomized bench for dff_en_pipe at DEPTH 4 (directed) and 1/2/4/5 (random).
module tb_dff_en_pipe;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_data;

  logic       rdy_a [4];
  logic       ov_a  [4];
  logic [7:0] od_a  [4];
  int         occ_a [4];
  logic [2:0] occ4;
  logic [0:0] occ1;
  logic [1:0] occ2;
  logic [2:0] occ5;

  int depth_a [4] = '{4, 1, 2, 5};
  int n_checks = 0;
  int n_fail   = 0;

  dff_en_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h5A)) u_d4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a[0]),
    .in_data(in_data), .out_valid(ov_a[0]), .out_ready(out_ready), .out_data(od_a[0]),
    .occupancy(occ4));
  dff_en_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h5A)) u_d1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a[1]),
    .in_data(in_data), .out_valid(ov_a[1]), .out_ready(out_ready), .out_data(od_a[1]),
    .occupancy(occ1));
  dff_en_pipe #(.WIDTH(8), .DEPTH(2), .RESET_VAL(8'h5A)) u_d2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a[2]),
    .in_data(in_data), .out_valid(ov_a[2]), .out_ready(out_ready), .out_data(od_a[2]),
    .occupancy(occ2));
  dff_en_pipe #(.WIDTH(8), .DEPTH(5), .RESET_VAL(8'h5A)) u_d5 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a[3]),
    .in_data(in_data), .out_valid(ov_a[3]), .out_ready(out_ready), .out_data(od_a[3]),
    .occupancy(occ5));

  always_comb begin
    occ_a[0] = int'(occ4);
    occ_a[1] = int'(occ1);
    occ_a[2] = int'(occ2);
    occ_a[3] = int'(occ5);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change 1 time unit after a rising edge; outputs are sampled 3 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at a sample point; returns further edges until out_valid (bounded).
  task automatic wait_out(output int edges);
    edges = 0;
    while (!ov_a[0] && edges < 20) begin
      tick();
      #3;
      edges++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
    tick();
    tick();
    #3;
    n_checks++; if (rdy_a[0] !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", rdy_a[0]); end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (ov_a[k] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid[%0d]: got %b want 0", k, ov_a[k]); end
      n_checks++; if (occ_a[k] !== 0) begin n_fail++; $display("FAIL reset_occupancy[%0d]: got %0d want 0", k, occ_a[k]); end
      n_checks++; if (od_a[k] !== 8'h5A) begin n_fail++; $display("FAIL reset_out_data[%0d]: got %h want 5a", k, od_a[k]); end
    end
    rst = 1'b1; in_valid = 1'b0;
    tick();
  endtask

  task automatic test_latency();
    int e;
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    #3;
    n_checks++; if (rdy_a[0] !== 1'b1) begin n_fail++; $display("FAIL lat_in_ready: got %b want 1", rdy_a[0]); end
    tick();
    in_valid = 1'b0;
    #3;
    n_checks++; if (occ_a[0] !== 1) begin n_fail++; $display("FAIL lat_occupancy: got %0d want 1", occ_a[0]); end
    wait_out(e);
    n_checks++; if (e !== 3) begin n_fail++; $display("FAIL lat_edges: got %0d want 3", e); end
    n_checks++; if (od_a[0] !== 8'hA5) begin n_fail++; $display("FAIL lat_data: got %h want a5", od_a[0]); end
    tick();
    #3;
    n_checks++; if (ov_a[0] !== 1'b0) begin n_fail++; $display("FAIL lat_drained: got %b want 0", ov_a[0]); end
    n_checks++; if (occ_a[0] !== 0) begin n_fail++; $display("FAIL lat_occ_end: got %0d want 0", occ_a[0]); end
    tick();
  endtask

  task automatic test_stall_fill();
    int nxt;
    out_ready = 1'b0;
    for (int w = 1; w <= 4; w++) begin
      in_valid = 1'b1; in_data = 8'(w);
      #3;
      n_checks++; if (rdy_a[0] !== 1'b1) begin n_fail++; $display("FAIL fill_in_ready_%0d: got %b want 1", w, rdy_a[0]); end
      tick();
    end
    in_data = 8'd5;
    for (int c = 0; c < 2; c++) begin
      #3;
      n_checks++; if (rdy_a[0] !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b want 0", rdy_a[0]); end
      n_checks++; if (occ_a[0] !== 4) begin n_fail++; $display("FAIL full_occupancy: got %0d want 4", occ_a[0]); end
      n_checks++; if ({ov_a[0], od_a[0]} !== {1'b1, 8'd1}) begin n_fail++; $display("FAIL full_out: got %b/%h want 1/01", ov_a[0], od_a[0]); end
      tick();
    end
    nxt = 5;
    for (int c = 0; c < 6; c++) begin
      out_ready = 1'b1; in_valid = (nxt <= 6); in_data = 8'(nxt);
      #3;
      n_checks++; if ({ov_a[0], od_a[0]} !== {1'b1, 8'(c + 1)}) begin n_fail++; $display("FAIL drain_word_%0d: got %b/%h want 1/%h", c, ov_a[0], od_a[0], 8'(c + 1)); end
      if (in_valid && rdy_a[0]) nxt++;
      tick();
    end
    n_checks++; if (nxt !== 7) begin n_fail++; $display("FAIL drain_accepts: got next word %0d want 7", nxt); end
    in_valid = 1'b0;
    #3;
    n_checks++; if ({ov_a[0], occ_a[0]} !== {1'b0, 32'd0}) begin n_fail++; $display("FAIL drain_empty: got %b/%0d want 0/0", ov_a[0], occ_a[0]); end
    tick();
  endtask

  task automatic test_bubble_collapse();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'd1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    in_valid = 1'b1; in_data = 8'd2;
    #3;
    n_checks++; if (rdy_a[0] !== 1'b1) begin n_fail++; $display("FAIL bub_in_ready: got %b want 1", rdy_a[0]); end
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    #3;
    n_checks++; if (occ_a[0] !== 2) begin n_fail++; $display("FAIL bub_occupancy: got %0d want 2", occ_a[0]); end
    n_checks++; if ({ov_a[0], od_a[0]} !== {1'b1, 8'd1}) begin n_fail++; $display("FAIL bub_head: got %b/%h want 1/01", ov_a[0], od_a[0]); end
    n_checks++; if (rdy_a[0] !== 1'b1) begin n_fail++; $display("FAIL bub_room: got %b want 1", rdy_a[0]); end
    out_ready = 1'b1;
    tick();
    #3;
    // Second word must already sit right behind the head: no gap after the first pop.
    n_checks++; if ({ov_a[0], od_a[0]} !== {1'b1, 8'd2}) begin n_fail++; $display("FAIL bub_packed: got %b/%h want 1/02", ov_a[0], od_a[0]); end
    tick();
    #3;
    n_checks++; if ({ov_a[0], od_a[0]} !== {1'b0, 8'd2}) begin n_fail++; $display("FAIL empty_hold: got %b/%h want 0/02", ov_a[0], od_a[0]); end
    n_checks++; if (occ_a[0] !== 0) begin n_fail++; $display("FAIL bub_occ_end: got %0d want 0", occ_a[0]); end
    tick();
  endtask

  task automatic test_flush();
    int e;
    logic [7:0] words [3] = '{8'h11, 8'h22, 8'h33};
    out_ready = 1'b0;
    for (int w = 0; w < 3; w++) begin
      in_valid = 1'b1; in_data = words[w];
      tick();
    end
    in_data = 8'h44; flush = 1'b1;
    #3;
    n_checks++; if (rdy_a[0] !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b want 0", rdy_a[0]); end
    n_checks++; if (occ_a[0] !== 3) begin n_fail++; $display("FAIL preflush_occ: got %0d want 3", occ_a[0]); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #3;
    n_checks++; if (occ_a[0] !== 0) begin n_fail++; $display("FAIL flush_occ: got %0d want 0", occ_a[0]); end
    n_checks++; if ({ov_a[0], od_a[0]} !== {1'b0, 8'h5A}) begin n_fail++; $display("FAIL flush_out: got %b/%h want 0/5a", ov_a[0], od_a[0]); end
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h07;
    #1;
    n_checks++; if (rdy_a[0] !== 1'b1) begin n_fail++; $display("FAIL postflush_ready: got %b want 1", rdy_a[0]); end
    tick();
    in_valid = 1'b0;
    #3;
    wait_out(e);
    n_checks++; if (e !== 3) begin n_fail++; $display("FAIL postflush_edges: got %0d want 3", e); end
    n_checks++; if (od_a[0] !== 8'h07) begin n_fail++; $display("FAIL postflush_data: got %h want 07", od_a[0]); end
    tick();
    #3;
    n_checks++; if ({ov_a[0], occ_a[0]} !== {1'b0, 32'd0}) begin n_fail++; $display("FAIL postflush_alone: got %b/%0d want 0/0", ov_a[0], occ_a[0]); end
    tick();
  endtask

  task automatic test_random();
    logic [7:0] mdl [4][16];
    int         hd  [4];
    int         cnt [4];
    logic       exp_rdy;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    tick();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      hd[k] = 0; cnt[k] = 0;
    end
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = 8'($urandom);
      #3;
      for (int k = 0; k < 4; k++) begin
        exp_rdy = (cnt[k] < depth_a[k]) || out_ready;
        n_checks++; if (occ_a[k] !== cnt[k]) begin n_fail++; if (n_fail < 20) $display("FAIL rnd_occ[%0d] cyc %0d: got %0d want %0d", k, c, occ_a[k], cnt[k]); end
        n_checks++; if (rdy_a[k] !== exp_rdy) begin n_fail++; if (n_fail < 20) $display("FAIL rnd_ready[%0d] cyc %0d: got %b want %b", k, c, rdy_a[k], exp_rdy); end
        if (cnt[k] == 0 || cnt[k] == depth_a[k]) begin
          n_checks++; if (ov_a[k] !== (cnt[k] != 0)) begin n_fail++; if (n_fail < 20) $display("FAIL rnd_valid[%0d] cyc %0d: got %b want %b", k, c, ov_a[k], cnt[k] != 0); end
        end
        if (ov_a[k] === 1'b1 && out_ready && cnt[k] > 0) begin
          n_checks++; if (od_a[k] !== mdl[k][hd[k]]) begin n_fail++; if (n_fail < 20) $display("FAIL rnd_order[%0d] cyc %0d: got %h want %h", k, c, od_a[k], mdl[k][hd[k]]); end
          hd[k] = (hd[k] + 1) % 16;
          cnt[k]--;
        end
        if (in_valid && rdy_a[k] === 1'b1) begin
          mdl[k][(hd[k] + cnt[k]) % 16] = in_data;
          cnt[k]++;
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stall_fill();
    test_bubble_collapse();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
